truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 173 +++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//
// Exhaustive stimulus generator and checker for an N_IN-input, 1-output
// combinational block. Walks every input vector 0..2^N_IN-1 in ascending
// order, holds each one for HOLD cycles, samples the function output on the
// last cycle of the hold window and compares it with the EXPECTED truth table.
// Mismatches are counted and the first failing vector is remembered.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   start            one-cycle sweep request, ignored while busy
//   abort            synchronous stop back to idle (wins over start)
//   dut_out          output of the function under test
//   vec              input vector driven to the function under test
//   busy             high while a sweep is running (including the done cycle)
//   sample_valid     pulse on each compare cycle
//   done             pulse in the cycle after the last compare
//   pass             result of the last completed sweep
//   err_count        mismatches in current/last sweep, saturating at 2^N_IN
//   first_fail_valid at least one mismatch in current/last sweep
//   first_fail_vec   first mismatching vector
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int                 N_IN     = 3,
    parameter int                 HOLD     = 10,
    parameter logic [2**N_IN-1:0] EXPECTED = 8'hE8,
    parameter bit                 LOOP     = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_out,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            sample_valid,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int                HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0]    HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [N_IN:0]     ERR_MAX   = (N_IN + 1)'(2**N_IN);
    localparam logic [N_IN-1:0]   VEC_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state,    w_state_next;
    logic [N_IN-1:0]   r_vec,      w_vec_next;
    logic [HCW-1:0]    r_hold_cnt, w_hold_cnt_next;
    logic [N_IN:0]     r_err,      w_err_next;
    logic              r_ffv,      w_ffv_next;
    logic [N_IN-1:0]   r_ffvec,    w_ffvec_next;
    logic              r_pass,     w_pass_next;
    logic              w_compare;
    logic              w_mismatch;
    logic              w_sample_valid;
    logic              w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_vec      <= '0;
            r_hold_cnt <= '0;
            r_err      <= '0;
            r_ffv      <= 1'b0;
            r_ffvec    <= '0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_vec      <= w_vec_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_err      <= w_err_next;
            r_ffv      <= w_ffv_next;
            r_ffvec    <= w_ffvec_next;
            r_pass     <= w_pass_next;
        end
    end

    // Compare on the last cycle of the hold window; HOLD=1 samples in the
    // same cycle the vector is applied.
    assign w_compare  = (r_state == S_HOLD) && (r_hold_cnt == HOLD_LAST);
    assign w_mismatch = (dut_out != EXPECTED[r_vec]);

    always_comb begin
        w_state_next    = r_state;
        w_vec_next      = r_vec;
        w_hold_cnt_next = r_hold_cnt;
        w_err_next      = r_err;
        w_ffv_next      = r_ffv;
        w_ffvec_next    = r_ffvec;
        w_pass_next     = r_pass;
        w_sample_valid  = 1'b0;
        w_done          = 1'b0;

        if (abort) begin
            // Results of the interrupted sweep stay visible; pass untouched.
            w_state_next    = S_IDLE;
            w_vec_next      = '0;
            w_hold_cnt_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_next    = S_HOLD;
                        w_vec_next      = '0;
                        w_hold_cnt_next = '0;
                        w_err_next      = '0;
                        w_ffv_next      = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_compare) begin
                        w_sample_valid = 1'b1;
                        if (w_mismatch) begin
                            if (r_err != ERR_MAX) begin
                                w_err_next = r_err + (N_IN + 1)'(1);
                            end
                            if (!r_ffv) begin
                                w_ffv_next   = 1'b1;
                                w_ffvec_next = r_vec;
                            end
                        end
                        w_hold_cnt_next = '0;
                        if (r_vec == VEC_LAST) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_vec_next = r_vec + N_IN'(1);
                        end
                    end else begin
                        w_hold_cnt_next = r_hold_cnt + HCW'(1);
                    end
                end
                S_DONE: begin
                    // r_err already includes the last vector's compare.
                    w_done      = 1'b1;
                    w_pass_next = (r_err == '0);
                    if (LOOP) begin
                        w_state_next    = S_HOLD;
                        w_vec_next      = '0;
                        w_hold_cnt_next = '0;
                        w_err_next      = '0;
                        w_ffv_next      = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign vec              = r_vec;
    assign busy             = (r_state != S_IDLE);
    assign sample_valid     = w_sample_valid;
    assign done             = w_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Two sweeper instances: A (N_IN=3, HOLD=10, EXPECTED=E8, single sweep) and
// B (N_IN=2, HOLD=1, EXPECTED=6, looping). The function under test is a
// lookup table fn_s[k] indexed by the instance's vec output. A cycle-count
// reference model predicts every output on every cycle; directed sections
// pin the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, rst_n_b;
    logic       start_a, start_b, abort_a, abort_b;
    logic [7:0] fn_a, fn_b;
    logic       dut_out_a, dut_out_b;

    logic [2:0] vec_a;
    logic       busy_a, sample_valid_a, done_a, pass_a, ffv_a;
    logic [3:0] err_a;
    logic [2:0] ffvec_a;

    logic [1:0] vec_b;
    logic       busy_b, sample_valid_b, done_b, pass_b, ffv_b;
    logic [2:0] err_b;
    logic [1:0] ffvec_b;

    assign dut_out_a = fn_a[vec_a];
    assign dut_out_b = fn_b[vec_b];

    truth_table_sweeper #(.N_IN(3), .HOLD(10), .EXPECTED(8'hE8), .LOOP(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .abort(abort_a),
        .dut_out(dut_out_a), .vec(vec_a), .busy(busy_a),
        .sample_valid(sample_valid_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
    );

    truth_table_sweeper #(.N_IN(2), .HOLD(1), .EXPECTED(4'h6), .LOOP(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .abort(abort_b),
        .dut_out(dut_out_b), .vec(vec_b), .busy(busy_b),
        .sample_valid(sample_valid_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model -----------------
    // A sweep is a count t of cycles since the start edge: vector t/HOLD is
    // applied, compares happen when t%HOLD==HOLD-1, and t==2^N*HOLD is the
    // done cycle.
    int m_act[2], m_t[2], m_ivec[2], m_err[2], m_ffv[2], m_ffvec[2], m_pass[2];

    function automatic int nv(input int k);   return (k == 0) ? 8 : 4;  endfunction
    function automatic int hl(input int k);   return (k == 0) ? 10 : 1; endfunction
    function automatic int lp(input int k);   return (k == 0) ? 0 : 1;  endfunction
    function automatic int ebit(input int k, input int v);
        int tbl;
        tbl = (k == 0) ? 'hE8 : 'h6;
        return (tbl >> v) & 1;
    endfunction
    function automatic int fbit(input int k, input int v);
        int tbl;
        tbl = (k == 0) ? int'(fn_a) : int'(fn_b);
        return (tbl >> v) & 1;
    endfunction
    function automatic bit get_start(input int k); return (k == 0) ? start_a : start_b; endfunction
    function automatic bit get_abort(input int k); return (k == 0) ? abort_a : abort_b; endfunction

    task automatic model_step(input int k, input bit rst_ok);
        int v;
        if (!rst_ok) begin
            m_act[k] = 0; m_t[k] = 0; m_ivec[k] = 0; m_err[k] = 0;
            m_ffv[k] = 0; m_ffvec[k] = 0; m_pass[k] = 0;
        end else if (get_abort(k)) begin
            m_act[k] = 0; m_ivec[k] = 0;
        end else if (m_act[k] == 0) begin
            if (get_start(k)) begin
                m_act[k] = 1; m_t[k] = 0; m_err[k] = 0; m_ffv[k] = 0;
            end
        end else if (m_t[k] < nv(k) * hl(k)) begin
            if (m_t[k] % hl(k) == hl(k) - 1) begin
                v = m_t[k] / hl(k);
                if (fbit(k, v) != ebit(k, v)) begin
                    if (m_err[k] < nv(k)) m_err[k]++;
                    if (m_ffv[k] == 0) begin m_ffv[k] = 1; m_ffvec[k] = v; end
                end
            end
            m_t[k]++;
        end else begin
            m_pass[k] = (m_err[k] == 0) ? 1 : 0;
            if (lp(k) != 0) begin
                m_t[k] = 0; m_err[k] = 0; m_ffv[k] = 0;
            end else begin
                m_act[k] = 0; m_ivec[k] = nv(k) - 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n_a) model_step(0, rst_n_a);
    always @(posedge clk or negedge rst_n_b) model_step(1, rst_n_b);

    function automatic int pack(input int v, input int b, input int sv, input int d,
                                input int p, input int e, input int fv, input int fvec);
        return v | (e << 8) | (fvec << 16) | (b << 24) | (sv << 25) | (d << 26)
                 | (p << 27) | (fv << 28);
    endfunction

    function automatic int model_outs(input int k);
        int v, sv, d, lim;
        lim = nv(k) * hl(k);
        if (m_act[k] != 0) v = (m_t[k] < lim) ? m_t[k] / hl(k) : nv(k) - 1;
        else               v = m_ivec[k];
        sv = (m_act[k] != 0 && m_t[k] < lim && (m_t[k] % hl(k) == hl(k) - 1)
              && !get_abort(k)) ? 1 : 0;
        d  = (m_act[k] != 0 && m_t[k] == lim && !get_abort(k)) ? 1 : 0;
        return pack(v, m_act[k], sv, d, m_pass[k], m_err[k], m_ffv[k], m_ffvec[k]);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("A outputs", pack(int'(vec_a), int'(busy_a), int'(sample_valid_a), int'(done_a),
                                  int'(pass_a), int'(err_a), int'(ffv_a), int'(ffvec_a)),
                model_outs(0));
            chk("B outputs", pack(int'(vec_b), int'(busy_b), int'(sample_valid_b), int'(done_b),
                                  int'(pass_b), int'(err_b), int'(ffv_b), int'(ffvec_b)),
                model_outs(1));
        end
    end

    // ---------------- stimulus -----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a sweep on A and records sample/done cycle numbers, counting the
    // start edge as cycle 0. Optional start pulses are injected mid-sweep.
    task automatic run_timed_a(input bit pulses, output int first_sv, output int last_sv,
                               output int nsv, output int dc);
        first_sv = -1; last_sv = -1; nsv = 0; dc = -1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 95; c++) begin
            @(negedge clk);
            if (sample_valid_a) begin
                if (first_sv < 0) first_sv = c;
                last_sv = c;
                nsv++;
            end
            if (done_a && dc < 0) dc = c;
            tick();
            start_a = pulses && (c < 70) && (c % 17 == 3);
        end
        start_a = 1'b0;
    endtask

    task automatic wait_vec_a(input int v);
        int n;
        n = 0;
        while (int'(vec_a) != v && n < 200) begin
            tick();
            n++;
        end
        chk("wait for vec_a", int'(int'(vec_a) == v), 1);
    endtask

    initial begin
        int fs, ls, ns, dc, nd, fd;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
        fn_a = 8'hE8;   // majority of 3
        fn_b = 8'h06;   // xor of 2
        repeat (2) tick();
        @(negedge clk);
        chk("reset busy_a", int'(busy_a), 0);
        chk("reset vec_a", int'(vec_a), 0);
        chk("reset pass_a", int'(pass_a), 0);
        chk("reset err_a", int'(err_a), 0);
        tick();
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        tick();
        chk_en = 1'b1;

        // B: looping xor sweep, done every 5 cycles
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        nd = 0; fd = -1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (done_b) begin nd++; if (fd < 0) fd = c; end
            chk("B vec sequence", int'(vec_b), ((c - 1) % 5 == 4) ? 3 : (c - 1) % 5);
            if (c == 12) chk("B pass", int'(pass_b), 1);
            tick();
        end
        chk("B first done cycle", fd, 5);
        chk("B done count", nd, 4);

        // A: majority matches
        run_timed_a(1'b0, fs, ls, ns, dc);
        chk("A first sample cycle", fs, 10);
        chk("A last sample cycle", ls, 80);
        chk("A sample count", ns, 8);
        chk("A done cycle", dc, 81);
        chk("A pass good", int'(pass_a), 1);
        chk("A err good", int'(err_a), 0);
        chk("A ffv good", int'(ffv_a), 0);

        // A: stuck-at-0 output
        fn_a = 8'h00;
        run_timed_a(1'b0, fs, ls, ns, dc);
        chk("A err stuck0", int'(err_a), 4);
        chk("A ffvec stuck0", int'(ffvec_a), 3);
        chk("A ffv stuck0", int'(ffv_a), 1);
        chk("A pass stuck0", int'(pass_a), 0);

        // A: abort while vec=5
        fn_a = 8'hE8;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_vec_a(5);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        @(negedge clk);
        chk("A busy after abort", int'(busy_a), 0);
        chk("A vec after abort", int'(vec_a), 0);
        chk("A pass after abort", int'(pass_a), 0);
        repeat (30) tick();
        run_timed_a(1'b0, fs, ls, ns, dc);
        chk("A done after abort", dc, 81);
        chk("A pass after rerun", int'(pass_a), 1);

        // A: start+abort together in idle, then start pulses while busy
        start_a = 1'b1; abort_a = 1'b1;
        tick();
        start_a = 1'b0; abort_a = 1'b0;
        @(negedge clk);
        chk("A idle after start+abort", int'(busy_a), 0);
        tick();
        run_timed_a(1'b1, fs, ls, ns, dc);
        chk("A done with start pulses", dc, 81);
        chk("A samples with start pulses", ns, 8);

        // A: reset mid-hold at vec=4 with errors accumulated
        fn_a = 8'h00;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_vec_a(4);
        repeat (3) tick();
        rst_n_a = 1'b0;
        #1;
        chk("A reset vec", int'(vec_a), 0);
        chk("A reset busy", int'(busy_a), 0);
        chk("A reset err", int'(err_a), 0);
        chk("A reset ffv", int'(ffv_a), 0);
        chk("A reset pass", int'(pass_a), 0);
        tick();
        rst_n_a = 1'b1;
        fn_a = 8'hE8;
        tick();
        run_timed_a(1'b0, fs, ls, ns, dc);
        chk("A first sample after reset", fs, 10);
        chk("A pass after reset sweep", int'(pass_a), 1);

        // Randomized phase: random tables, start/abort/reset on both instances
        for (int i = 0; i < 3000; i++) begin
            start_a = ($urandom % 16 == 0);
            abort_a = ($urandom % 400 == 0);
            rst_n_a = ($urandom % 900 != 0);
            if ($urandom % 300 == 0) begin
                case ($urandom % 3)
                    0:       fn_a = 8'hE8;
                    1:       fn_a = 8'hE8 ^ (8'h01 << ($urandom % 8));
                    default: fn_a = 8'($urandom);
                endcase
            end
            start_b = ($urandom % 10 == 0);
            abort_b = ($urandom % 300 == 0);
            rst_n_b = ($urandom % 1000 != 0);
            if ($urandom % 200 == 0) fn_b = ($urandom % 2 == 0) ? 8'h06 : 8'($urandom % 16);
            tick();
        end
        start_a = 1'b0; abort_a = 1'b0; rst_n_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; rst_n_b = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
